// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and counter widths.
package pll_seq_pkg;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RESET   = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_FILTER = 3'd2,
    ST_RELEASE     = 3'd3,
    ST_RUN         = 3'd4,
    ST_FAIL        = 3'd5
  } state_e;

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer; both stages clear to zero on reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, filtered lock detection and staggered domain reset release,
// with timeout retries, a sticky fail state and lock-loss recovery.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned STAGGER      = 8,
  parameter int unsigned NUM_DOMAINS  = 2,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned CNT_W        = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   restart,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   seq_ready,
  output logic                   seq_fail,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count,
  output logic [STATE_W-1:0]     seq_state
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic w_lock_s;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [RETRY_W-1:0]     r_retries;
  logic [NUM_DOMAINS-1:0] r_dom_n;
  logic [LOSS_CNT_W-1:0]  r_loss;
  logic                   r_pll_rst;
  logic                   r_ready;
  logic                   r_fail;

  state_e                 w_state_nx;
  logic [CNT_W-1:0]       w_cnt_nx;
  logic [RETRY_W-1:0]     w_retries_nx;
  logic [NUM_DOMAINS-1:0] w_dom_nx;
  logic [NUM_DOMAINS-1:0] w_dom_shift;
  logic [LOSS_CNT_W-1:0]  w_loss_nx;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Releasing a domain shifts a one in from bit 0, so the lowest index goes first.
  assign w_dom_shift = (r_dom_n << 1) | NUM_DOMAINS'(1);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 1'b1;
    w_retries_nx = r_retries;
    w_dom_nx     = r_dom_n;
    w_loss_nx    = r_loss;

    if (restart) begin
      w_state_nx   = ST_PLL_RESET;
      w_cnt_nx     = '0;
      w_retries_nx = '0;
      w_dom_nx     = '0;
    end else begin
      case (r_state)
        ST_PLL_RESET: begin
          w_dom_nx = '0;
          if (r_cnt == RST_LAST) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nx = ST_LOCK_FILTER;
            w_cnt_nx   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_cnt_nx = '0;
            if (r_retries == RETRY_LIMIT) begin
              w_state_nx = ST_FAIL;
            end else begin
              w_state_nx   = ST_PLL_RESET;
              w_retries_nx = r_retries + 1'b1;
            end
          end
        end
        ST_LOCK_FILTER: begin
          if (!w_lock_s) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nx   = ST_RELEASE;
            w_cnt_nx     = '0;
            w_retries_nx = '0;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!w_lock_s) begin
            w_state_nx = ST_PLL_RESET;
            w_cnt_nx   = '0;
            w_dom_nx   = '0;
            if (r_loss != '1) begin
              w_loss_nx = r_loss + 1'b1;
            end
          end else if (r_state == ST_RUN) begin
            w_cnt_nx = '0;
          end else if (r_cnt == STAGGER_LAST) begin
            w_cnt_nx = '0;
            w_dom_nx = w_dom_shift;
            if (w_dom_shift == '1) begin
              w_state_nx = ST_RUN;
            end
          end
        end
        ST_FAIL: begin
          w_cnt_nx = '0;
          w_dom_nx = '0;
        end
        default: begin
          w_state_nx = ST_PLL_RESET;
          w_cnt_nx   = '0;
          w_dom_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_PLL_RESET;
      r_cnt     <= '0;
      r_retries <= '0;
      r_dom_n   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_retries <= w_retries_nx;
      r_dom_n   <= w_dom_nx;
      r_loss    <= w_loss_nx;
      r_pll_rst <= (w_state_nx == ST_PLL_RESET) || (w_state_nx == ST_FAIL);
      r_ready   <= (w_state_nx == ST_RUN);
      r_fail    <= (w_state_nx == ST_FAIL);
    end
  end

  assign pll_rst         = r_pll_rst;
  assign domain_reset_n  = r_dom_n;
  assign seq_ready       = r_ready;
  assign seq_fail        = r_fail;
  assign lock_loss_count = r_loss;
  assign seq_state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for pll_reset_sequencer using a short-parameter build.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic [1:0] domain_reset_n;
  logic       seq_ready;
  logic       seq_fail;
  logic [7:0] lock_loss_count;
  logic [2:0] seq_state;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .STAGGER      (2),
    .NUM_DOMAINS  (2),
    .MAX_RETRIES  (2),
    .CNT_W        (17)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .domain_reset_n  (domain_reset_n),
    .seq_ready       (seq_ready),
    .seq_fail        (seq_fail),
    .lock_loss_count (lock_loss_count),
    .seq_state       (seq_state)
  );

  typedef struct {
    int unsigned n;    // clock edges to advance after driving inputs
    logic        lk;
    logic        rs;
    logic        rst;
    logic [1:0]  dom;
    logic        rdy;
    logic        fl;
    logic [2:0]  st;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int unsigned n, input logic lk, input logic rs,
                              input logic rst, input logic [1:0] dom, input logic rdy,
                              input logic fl, input logic [2:0] st, input logic [7:0] cnt);
    vec_t v;
    v.n = n; v.lk = lk; v.rs = rs; v.rst = rst; v.dom = dom;
    v.rdy = rdy; v.fl = fl; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input vec_t v);
    logic [14:0] got;
    logic [14:0] exp;
    got = {pll_rst, domain_reset_n, seq_ready, seq_fail, seq_state, lock_loss_count};
    exp = {v.rst, v.dom, v.rdy, v.fl, v.st, v.cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rst=%b dom=%b rdy=%b fail=%b st=%0d loss=%0d, expected rst=%b dom=%b rdy=%b fail=%b st=%0d loss=%0d",
               name, pll_rst, domain_reset_n, seq_ready, seq_fail, seq_state, lock_loss_count,
               v.rst, v.dom, v.rdy, v.fl, v.st, v.cnt);
    end
  endtask

  initial begin
    // Nominal bring-up, relative to reset release (edge 0); lock raised after edge 10
    tbl.push_back(mk(0, 0,0, 1,2'b00,0,0,3'd0,8'd0));
    tbl.push_back(mk(3, 0,0, 1,2'b00,0,0,3'd0,8'd0));
    tbl.push_back(mk(1, 0,0, 0,2'b00,0,0,3'd1,8'd0));
    tbl.push_back(mk(6, 0,0, 0,2'b00,0,0,3'd1,8'd0));
    tbl.push_back(mk(2, 1,0, 0,2'b00,0,0,3'd1,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd2,8'd0));
    tbl.push_back(mk(7, 1,0, 0,2'b00,0,0,3'd2,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd3,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd3,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b01,0,0,3'd3,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b01,0,0,3'd3,8'd0));
    tbl.push_back(mk(1, 1,0, 0,2'b11,1,0,3'd4,8'd0));
    // Lock loss in RUN: visible three edges after the drop
    tbl.push_back(mk(2, 0,0, 0,2'b11,1,0,3'd4,8'd0));
    tbl.push_back(mk(1, 0,0, 1,2'b00,0,0,3'd0,8'd1));
    // Recovery with a one-cycle glitch inside the lock filter
    tbl.push_back(mk(4, 0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(5, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(1, 0,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(7, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd3,8'd1));
    tbl.push_back(mk(4, 1,0, 0,2'b11,1,0,3'd4,8'd1));
    // Restart from RUN, then restart in RELEASE on the same edge the lock loss is seen
    tbl.push_back(mk(1, 1,1, 1,2'b00,0,0,3'd0,8'd1));
    tbl.push_back(mk(4, 1,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(7, 1,0, 0,2'b00,0,0,3'd2,8'd1));
    tbl.push_back(mk(1, 1,0, 0,2'b00,0,0,3'd3,8'd1));
    tbl.push_back(mk(2, 0,0, 0,2'b01,0,0,3'd3,8'd1));
    tbl.push_back(mk(1, 0,1, 1,2'b00,0,0,3'd0,8'd1));
    // Three timeouts with lock held low, then FAIL
    tbl.push_back(mk(4, 0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(31,0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(1, 0,0, 1,2'b00,0,0,3'd0,8'd1));
    tbl.push_back(mk(3, 0,0, 1,2'b00,0,0,3'd0,8'd1));
    tbl.push_back(mk(1, 0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(32,0,0, 1,2'b00,0,0,3'd0,8'd1));
    tbl.push_back(mk(4, 0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(31,0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(1, 0,0, 1,2'b00,0,1,3'd5,8'd1));
    tbl.push_back(mk(5, 0,0, 1,2'b00,0,1,3'd5,8'd1));
    // Restart out of FAIL; retries cleared, so the next timeout retries instead of failing
    tbl.push_back(mk(1, 0,1, 1,2'b00,0,0,3'd0,8'd1));
    tbl.push_back(mk(4, 0,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(32,0,0, 1,2'b00,0,0,3'd0,8'd1));
    // Bring up to mid-RELEASE for the asynchronous reset case
    tbl.push_back(mk(4, 1,0, 0,2'b00,0,0,3'd1,8'd1));
    tbl.push_back(mk(9, 1,0, 0,2'b00,0,0,3'd3,8'd1));
    tbl.push_back(mk(2, 1,0, 0,2'b01,0,0,3'd3,8'd1));

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick(3);
    check("reset_state", mk(0, 0,0, 1,2'b00,0,0,3'd0,8'd0));
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      pll_locked = tbl[i].lk;
      restart    = tbl[i].rs;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset asserted between edges must act without a clock edge
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_now", mk(0, 0,0, 1,2'b00,0,0,3'd0,8'd0));
    tick(2);
    check("async_reset_held", mk(0, 0,0, 1,2'b00,0,0,3'd0,8'd0));
    reset_n = 1'b1;
    tick(1);
    check("after_reset_release", mk(0, 0,0, 1,2'b00,0,0,3'd0,8'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
